// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Pipeline sequencing controller for the 5-stage RISC-V core. It covers the
// hazards that forwarding cannot resolve: load-use stalls, taken-branch
// flushes, data-memory wait states and multi-cycle mul/div occupancy.
// It drives the per-stage write enables and bubble (flush) controls.
//
// Optional feature: define HAZ_PERF_CNT_EN to add the saturating
// Stall_Cycles_o / Flush_Cnt_o performance counters.
//
// Handshake semantics:
//   Dmem_Req_i/Dmem_Ready_i: an access is in MEM while Dmem_Req_i is high, and
//   it completes in the cycle Dmem_Ready_i is high. A request that is not ready
//   freezes the pipe until the ready cycle. Release happens in that ready cycle.
//   MulDiv_Start_i/MulDiv_Done_i behave the same way for the op held in EX,
//   with a forced release after MD_TIMEOUT frozen cycles.
module hazard_stall_controller #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RD_i,
  input  logic [4:0]       IF_ID_RS_i,
  input  logic [4:0]       IF_ID_RT_i,
  input  logic             IF_ID_UsesRT_i,
  input  logic             Branch_Taken_i,
  input  logic             Dmem_Req_i,
  input  logic             Dmem_Ready_i,
  input  logic             MulDiv_Start_i,
  input  logic             MulDiv_Done_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             ID_EX_Write_o,
  output logic             EX_MEM_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Flush_o,
  output logic             EX_MEM_Flush_o,
  output logic             MEM_WB_Flush_o,
  output logic [1:0]       State_o,
  output logic             MD_Timeout_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] Stall_Cycles_o,
  output logic [CNT_W-1:0] Flush_Cnt_o
`endif
);

  // Counter holds at most MD_TIMEOUT-1 while busy; one spare bit is harmless.
  localparam int MD_CNT_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_TIMEOUT - 1);

  // Reject parameter values the timeout and counter logic cannot support.
  if (MD_TIMEOUT < 2 || CNT_W < 1) begin : g_param_check
    $error("hazard_stall_controller: MD_TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_MD_BUSY  = 2'b10
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [MD_CNT_W-1:0] md_cnt;
  logic                md_enter;
  logic                md_force;
  logic                branch_flush;
  logic                load_use;
  logic                mem_stall;
  logic                md_stall;

  assign load_use  = ID_EX_MemRead_i && (ID_EX_RD_i != 5'd0) &&
                     ((ID_EX_RD_i == IF_ID_RS_i) ||
                      (IF_ID_UsesRT_i && (ID_EX_RD_i == IF_ID_RT_i)));
  assign mem_stall = Dmem_Req_i && !Dmem_Ready_i;
  assign md_stall  = MulDiv_Start_i && !MulDiv_Done_i;
  assign State_o   = state;

  // Stage controls and next state, from the current state and hazard inputs.
  always_comb begin
    PC_Write_o     = 1'b1;
    IF_ID_Write_o  = 1'b1;
    ID_EX_Write_o  = 1'b1;
    EX_MEM_Write_o = 1'b1;
    IF_ID_Flush_o  = 1'b0;
    ID_EX_Flush_o  = 1'b0;
    EX_MEM_Flush_o = 1'b0;
    MEM_WB_Flush_o = 1'b0;
    next_state     = state;
    md_enter       = 1'b0;
    md_force       = 1'b0;
    branch_flush   = 1'b0;
    if (rst_i) begin
      // Hold every register and bubble every stage so the pipe clears.
      PC_Write_o     = 1'b0;
      IF_ID_Write_o  = 1'b0;
      ID_EX_Write_o  = 1'b0;
      EX_MEM_Write_o = 1'b0;
      IF_ID_Flush_o  = 1'b1;
      ID_EX_Flush_o  = 1'b1;
      EX_MEM_Flush_o = 1'b1;
      MEM_WB_Flush_o = 1'b1;
      next_state     = ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (mem_stall) begin
            PC_Write_o     = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Write_o  = 1'b0;
            EX_MEM_Write_o = 1'b0;
            MEM_WB_Flush_o = 1'b1;
            next_state     = ST_MEM_WAIT;
          end else if (md_stall) begin
            PC_Write_o     = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Write_o  = 1'b0;
            EX_MEM_Flush_o = 1'b1;
            next_state     = ST_MD_BUSY;
            md_enter       = 1'b1;
          end else if (Branch_Taken_i) begin
            // Squash both younger instructions; a pending load-use is moot.
            IF_ID_Flush_o = 1'b1;
            ID_EX_Flush_o = 1'b1;
            branch_flush  = 1'b1;
          end else if (load_use) begin
            PC_Write_o    = 1'b0;
            IF_ID_Write_o = 1'b0;
            ID_EX_Flush_o = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (Dmem_Ready_i) begin
            next_state = ST_RUN;
          end else begin
            PC_Write_o     = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Write_o  = 1'b0;
            EX_MEM_Write_o = 1'b0;
            MEM_WB_Flush_o = 1'b1;
          end
        end
        ST_MD_BUSY: begin
          // Done wins over a coinciding timeout, so no pulse in that case.
          if (MulDiv_Done_i) begin
            next_state = ST_RUN;
          end else if (md_cnt == MD_LAST) begin
            next_state = ST_RUN;
            md_force   = 1'b1;
          end else begin
            PC_Write_o     = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Write_o  = 1'b0;
            EX_MEM_Flush_o = 1'b1;
          end
        end
        default: begin
          next_state = ST_RUN;
        end
      endcase
    end
  end

  // State register, mul/div occupancy counter and registered timeout pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_RUN;
      md_cnt       <= '0;
      MD_Timeout_o <= 1'b0;
    end else begin
      state        <= next_state;
      MD_Timeout_o <= md_force;
      if (md_enter) begin
        md_cnt <= '0;
      end else if (state == ST_MD_BUSY) begin
        md_cnt <= md_cnt + 1'b1;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating counts of PC-stalled cycles and taken-branch flushes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      Stall_Cycles_o <= '0;
      Flush_Cnt_o    <= '0;
    end else begin
      if (!PC_Write_o && (Stall_Cycles_o != '1)) begin
        Stall_Cycles_o <= Stall_Cycles_o + 1'b1;
      end
      if (branch_flush && (Flush_Cnt_o != '1)) begin
        Flush_Cnt_o <= Flush_Cnt_o + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller (MD_TIMEOUT overridden to 8).
// Expected control vectors are hand-computed and queued in exp_q; each step
// drives inputs after the rising edge and compares at the falling edge.
module tb_hazard_stall_controller;

  localparam int MD_TIMEOUT = 8;
  localparam int CNT_W      = 32;

  // Control nibbles: {PC, IF_ID, ID_EX, EX_MEM writes, IF_ID, ID_EX, EX_MEM, MEM_WB flushes}
  localparam logic [7:0] C_NORM = 8'b1111_0000;
  localparam logic [7:0] C_LU   = 8'b0011_0100;
  localparam logic [7:0] C_BR   = 8'b1111_1100;
  localparam logic [7:0] C_MEM  = 8'b0000_0001;
  localparam logic [7:0] C_MD   = 8'b0001_0010;
  localparam logic [7:0] C_RST  = 8'b0000_1111;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read;
  logic [4:0] ex_rd;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       uses_rt;
  logic       br_taken;
  logic       dmem_req;
  logic       dmem_ready;
  logic       md_start;
  logic       md_done;
  logic       pc_w, ifid_w, idex_w, exmem_w;
  logic       ifid_f, idex_f, exmem_f, memwb_f;
  logic [1:0] state;
  logic       md_to;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_cnt;
`endif

  logic [31:0] exp_q[$];
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;

  hazard_stall_controller #(
    .MD_TIMEOUT(MD_TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ID_EX_MemRead_i(mem_read),
    .ID_EX_RD_i     (ex_rd),
    .IF_ID_RS_i     (id_rs),
    .IF_ID_RT_i     (id_rt),
    .IF_ID_UsesRT_i (uses_rt),
    .Branch_Taken_i (br_taken),
    .Dmem_Req_i     (dmem_req),
    .Dmem_Ready_i   (dmem_ready),
    .MulDiv_Start_i (md_start),
    .MulDiv_Done_i  (md_done),
    .PC_Write_o     (pc_w),
    .IF_ID_Write_o  (ifid_w),
    .ID_EX_Write_o  (idex_w),
    .EX_MEM_Write_o (exmem_w),
    .IF_ID_Flush_o  (ifid_f),
    .ID_EX_Flush_o  (idex_f),
    .EX_MEM_Flush_o (exmem_f),
    .MEM_WB_Flush_o (memwb_f),
    .State_o        (state),
    .MD_Timeout_o   (md_to)
`ifdef HAZ_PERF_CNT_EN
    ,
    .Stall_Cycles_o (stall_cycles),
    .Flush_Cnt_o    (flush_cnt)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic br,
                       input logic req, input logic rdy, input logic st, input logic dn);
    mem_read   = mr;
    ex_rd      = rd;
    id_rs      = rs;
    id_rt      = rt;
    uses_rt    = urt;
    br_taken   = br;
    dmem_req   = req;
    dmem_ready = rdy;
    md_start   = st;
    md_done    = dn;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One cycle: queue the expectation, compare mid-cycle, advance past the edge.
  task automatic step(input string tag, input logic [1:0] st, input logic [7:0] ctl,
                      input logic to);
    logic [31:0] obs;
    logic [31:0] exp;
    exp_q.push_back({21'd0, st, ctl, to});
    @(negedge clk);
    obs = {21'd0, state, pc_w, ifid_w, idex_w, exmem_w,
           ifid_f, idex_f, exmem_f, memwb_f, md_to};
    exp = exp_q.pop_front();
    chk(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step("reset0", 2'b00, C_RST, 1'b0);
    step("reset1", 2'b00, C_RST, 1'b0);
    rst = 1'b0;
    step("idle", 2'b00, C_NORM, 1'b0);

    // Load-use detection
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_rs", 2'b00, C_LU, 1'b0);
    idle();
    step("lu_one_cycle", 2'b00, C_NORM, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_rd0", 2'b00, C_NORM, 1'b0);
    drive(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_rt", 2'b00, C_LU, 1'b0);
    drive(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_rt_unused", 2'b00, C_NORM, 1'b0);
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("br_over_lu", 2'b00, C_BR, 1'b0);
    idle();
    step("br_after", 2'b00, C_NORM, 1'b0);

    // Data-memory wait: entry plus three not-ready cycles, then ready
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("mem_entry", 2'b00, C_MEM, 1'b0);
    for (int i = 0; i < 3; i++) step("mem_wait", 2'b01, C_MEM, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("mem_release", 2'b01, C_NORM, 1'b0);
    idle();
    step("mem_after", 2'b00, C_NORM, 1'b0);

    // Mul/div: done five cycles after start
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("md_entry", 2'b00, C_MD, 1'b0);
    for (int i = 0; i < 4; i++) step("md_busy", 2'b10, C_MD, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("md_done", 2'b10, C_NORM, 1'b0);
    idle();
    step("md_after", 2'b00, C_NORM, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("md_same_cycle", 2'b00, C_NORM, 1'b0);

    // Priority: memory wait first, then mul/div; Dmem ignored while busy
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step("prio_mem", 2'b00, C_MEM, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("prio_mem_rel", 2'b01, C_NORM, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("prio_md", 2'b00, C_MD, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step("md_ignore_dmem", 2'b10, C_MD, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("prio_md_done", 2'b10, C_NORM, 1'b0);
    idle();
    step("prio_after", 2'b00, C_NORM, 1'b0);

    // Timeout: 8 frozen cycles, release, pulse in the following cycle
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("to_entry", 2'b00, C_MD, 1'b0);
    for (int i = 0; i < 7; i++) step("to_busy", 2'b10, C_MD, 1'b0);
    step("to_release", 2'b10, C_NORM, 1'b0);
    idle();
    step("to_pulse", 2'b00, C_NORM, 1'b1);
    step("to_pulse_end", 2'b00, C_NORM, 1'b0);

    // Done coinciding with timeout counts as done
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("tod_entry", 2'b00, C_MD, 1'b0);
    for (int i = 0; i < 7; i++) step("tod_busy", 2'b10, C_MD, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("tod_done_wins", 2'b10, C_NORM, 1'b0);
    idle();
    step("tod_no_pulse", 2'b00, C_NORM, 1'b0);

`ifdef HAZ_PERF_CNT_EN
    @(negedge clk);
    chk("perf_stall", 32'(stall_cycles), 32'd30);
    chk("perf_flush", 32'(flush_cnt), 32'd1);
    @(posedge clk);
    #1;
`endif

    // Reset in the middle of MD_BUSY
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rst_md_entry", 2'b00, C_MD, 1'b0);
    step("rst_md_busy", 2'b10, C_MD, 1'b0);
    rst = 1'b1;
    step("rst_in_md", 2'b10, C_RST, 1'b0);
    step("rst_hold", 2'b00, C_RST, 1'b0);
    rst = 1'b0;
    idle();
    step("rst_after", 2'b00, C_NORM, 1'b0);

`ifdef HAZ_PERF_CNT_EN
    @(negedge clk);
    chk("perf_stall_rst", 32'(stall_cycles), 32'd0);
    chk("perf_flush_rst", 32'(flush_cnt), 32'd0);
    @(posedge clk);
    #1;
`endif

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline sequencing controller for the 5-stage RISC-V core. Sits beside the forwarding unit and covers the hazards forwarding cannot resolve:
- load-use stalls;
- taken-branch flushes;
- data-memory wait states;
- multi-cycle mul/div occupancy.

It drives per-stage write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB from a small FSM plus a timeout counter.

## Interface
Parameters:
- MD_TIMEOUT, 64: max MD_BUSY cycles before forced release (≥2).
- CNT_W, 32: perf counter width (used only with HAZ_PERF_CNT_EN).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ID_EX_MemRead_i  in  1  instruction in EX is a load.
- ID_EX_RD_i  in  5  destination of instruction in EX.
- IF_ID_RS_i  in  5  rs1 of instruction in ID.
- IF_ID_RT_i  in  5  rs2 of instruction in ID.
- IF_ID_UsesRT_i  in  1  ID instruction reads rs2.
- Branch_Taken_i  in  1  branch/jump resolved taken in EX.
- Dmem_Req_i  in  1  MEM-stage data-memory access active.
- Dmem_Ready_i  in  1  data memory completes access this cycle.
- MulDiv_Start_i  in  1  mul/div op present in EX.
- MulDiv_Done_i  in  1  mul/div result valid this cycle.
- PC_Write_o, IF_ID_Write_o, ID_EX_Write_o, EX_MEM_Write_o  out  1 each  stage register enables.
- IF_ID_Flush_o, ID_EX_Flush_o, EX_MEM_Flush_o, MEM_WB_Flush_o  out  1 each  insert bubble into the named register.
- State_o  out  2  00 RUN, 01 MEM_WAIT, 10 MD_BUSY.
- MD_Timeout_o  out  1  one-cycle pulse on forced mul/div release.

## Operation
- Controls are combinational from state and inputs. State, counter and MD_Timeout_o are registered.
- Load-use hazard (RUN only):
  - Condition: ID_EX_MemRead_i && ID_EX_RD_i≠0 && (ID_EX_RD_i==IF_ID_RS_i || (IF_ID_UsesRT_i && ID_EX_RD_i==IF_ID_RT_i)).
  - Response: PC_Write_o=0, IF_ID_Write_o=0, ID_EX_Flush_o=1, for exactly one cycle. No state change.
- Branch (RUN only): Branch_Taken_i → IF_ID_Flush_o=1, ID_EX_Flush_o=1. Branch beats load-use: no stall; both younger instructions are squashed.
- MEM_WAIT:
  - Entry: in RUN, Dmem_Req_i && !Dmem_Ready_i.
  - While waiting: all four *_Write_o=0 and MEM_WB_Flush_o=1, including the entry cycle.
  - The cycle Dmem_Ready_i=1: release with normal controls, next state RUN.
- MD_BUSY:
  - Entry: in RUN, MulDiv_Start_i && !MulDiv_Done_i.
  - While busy: PC/IF_ID/ID_EX writes=0 and EX_MEM_Flush_o=1, including the entry cycle.
  - The cycle MulDiv_Done_i=1: release, EX_MEM_Write_o=1, next state RUN.
  - Counter clears on entry and increments each MD_BUSY cycle. At MD_TIMEOUT: release, pulse MD_Timeout_o, return to RUN.
- Priority in RUN: MEM_WAIT > MD_BUSY > branch > load-use.
  - A frozen EX keeps MulDiv_Start_i and Branch_Taken_i asserted; they are acted on after release.
- Dmem_Req_i is ignored in MD_BUSY. MEM holds bubbles after the entry cycle.
- Default (RUN, no hazard): all writes=1, all flushes=0.

## Timing
- Reset (rst_i=1 at edge): state RUN, counter 0, MD_Timeout_o=0, perf counters 0.
- While rst_i=1: all *_Write_o=0 and all *_Flush_o=1, so the pipeline clears. Reset mid-MEM_WAIT or mid-MD_BUSY aborts to RUN on the next edge.
- Load-use: exactly 1 stall cycle. No added latency beyond the condition.
- MEM_WAIT lasts N+1 frozen cycles for N extra not-ready cycles. Release is in the ready cycle itself.
- Same-cycle start and done in RUN: no state entry, zero stall.
- Timeout fires after MD_TIMEOUT frozen cycles. A simultaneous done and timeout counts as done: no pulse.

## Configuration
- HAZ_PERF_CNT_EN defined: adds outputs Stall_Cycles_o[CNT_W-1:0] and Flush_Cnt_o[CNT_W-1:0], both saturating at all-ones.
  - Stall_Cycles_o increments each cycle PC_Write_o=0 (outside reset).
  - Flush_Cnt_o increments on each taken-branch flush.
- Undefined: these ports and their registers do not exist. All other behaviour is identical.

## Test plan
- Load-use: EX has lw x5 with ID_EX_MemRead_i=1, RD=5; ID has rs1=5 → one cycle with PC_Write_o=0, IF_ID_Write_o=0, ID_EX_Flush_o=1. Same with RD=0 → no stall.
- Branch vs load-use: Branch_Taken_i=1 with load-use true → IF_ID_Flush_o=ID_EX_Flush_o=1, PC_Write_o=1.
- Memory wait: Dmem_Req_i=1, Dmem_Ready_i=0 for 3 cycles, then 1 → 4 frozen cycles with State_o=01 for 3, MEM_WB_Flush_o=1; RUN afterwards.
- Mul/div: start, then done 5 cycles later → 6 cycles of EX_MEM_Flush_o=1 in the first 5, EX_MEM_Write_o=1 on the done cycle. With MD_TIMEOUT=8 and no done → MD_Timeout_o pulses once, RUN resumes.
- Priority/reset: Dmem wait and MulDiv_Start_i together → MEM_WAIT first, then MD_BUSY. rst_i asserted in MD_BUSY → State_o=00 and all flushes high while asserted.
- HAZ_PERF_CNT_EN: preceding sequence → Stall_Cycles_o equals the number of PC_Write_o=0 cycles. Flush_Cnt_o=1 after one branch.
